// File: rtl/riscv_pkg.sv
// Shared integer-pipeline constants: data width, register file geometry and the x0 index.
package riscv_pkg;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/wb_regfile_if.sv
// MEM/WB write-back bundle plus the ID-stage read ports of the integer register file.
interface wb_regfile_if
    import riscv_pkg::*;
#(
    parameter int XLEN  = riscv_pkg::XLEN,
    parameter int CNT_W = 32
);
    logic                  mem_to_reg_in;
    logic                  reg_write_in;
    logic [XLEN-1:0]       read_data_in;
    logic [XLEN-1:0]       alu_result_in;
    logic [REG_ADDR_W-1:0] reg_rd_in;
    logic [REG_ADDR_W-1:0] rs1_addr;
    logic [REG_ADDR_W-1:0] rs2_addr;
    logic [XLEN-1:0]       rs1_data;
    logic [XLEN-1:0]       rs2_data;
    logic [XLEN-1:0]       wb_data;
    logic                  wb_commit;
    logic [CNT_W-1:0]      commit_count;

    modport master (
        output mem_to_reg_in, reg_write_in, read_data_in, alu_result_in,
               reg_rd_in, rs1_addr, rs2_addr,
        input  rs1_data, rs2_data, wb_data, wb_commit, commit_count
    );

    modport slave (
        input  mem_to_reg_in, reg_write_in, read_data_in, alu_result_in,
               reg_rd_in, rs1_addr, rs2_addr,
        output rs1_data, rs2_data, wb_data, wb_commit, commit_count
    );
endinterface

// File: rtl/wb_regfile_register_bank.sv
// Architectural register storage: one synchronous write port, two asynchronous read ports, x0 tied to zero.
module register_bank
    import riscv_pkg::*;
#(
    parameter int XLEN     = riscv_pkg::XLEN,
    parameter int NUM_REGS = riscv_pkg::NUM_REGS
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  we,
    input  logic [REG_ADDR_W-1:0] waddr,
    input  logic [XLEN-1:0]       wdata,
    input  logic [REG_ADDR_W-1:0] raddr1,
    input  logic [REG_ADDR_W-1:0] raddr2,
    output logic [XLEN-1:0]       rdata1,
    output logic [XLEN-1:0]       rdata2
);
    logic [XLEN-1:0] regs [NUM_REGS];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != REG_ZERO)) begin
            regs[waddr] <= wdata;
        end
    end

    // x0 is forced on the read side so the storage entry never matters.
    assign rdata1 = (raddr1 == REG_ZERO) ? '0 : regs[raddr1];
    assign rdata2 = (raddr2 == REG_ZERO) ? '0 : regs[raddr2];
endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: selects load/ALU result, commits it to the register bank, bypasses it to ID reads.
module wb_regfile
    import riscv_pkg::*;
#(
    parameter int XLEN     = riscv_pkg::XLEN,
    parameter int NUM_REGS = riscv_pkg::NUM_REGS,
    parameter int CNT_W    = 32
) (
    input  logic         clock,
    input  logic         reset,
    wb_regfile_if.slave  bus
);
    logic [XLEN-1:0]  wb_data;
    logic             wb_commit;
    logic [XLEN-1:0]  bank_rdata1;
    logic [XLEN-1:0]  bank_rdata2;
    logic [XLEN-1:0]  rs1_data;
    logic [XLEN-1:0]  rs2_data;
    logic [CNT_W-1:0] commit_count;

    assign wb_data   = bus.mem_to_reg_in ? bus.read_data_in : bus.alu_result_in;
    assign wb_commit = bus.reg_write_in && (bus.reg_rd_in != REG_ZERO);

    register_bank #(
        .XLEN     (XLEN),
        .NUM_REGS (NUM_REGS)
    ) u_bank (
        .clock  (clock),
        .reset  (reset),
        .we     (wb_commit),
        .waddr  (bus.reg_rd_in),
        .wdata  (wb_data),
        .raddr1 (bus.rs1_addr),
        .raddr2 (bus.rs2_addr),
        .rdata1 (bank_rdata1),
        .rdata2 (bank_rdata2)
    );

    // The value being committed this cycle is forwarded so ID never sees a stale register.
    always_comb begin
        rs1_data = bank_rdata1;
        rs2_data = bank_rdata2;
        if (bus.rs1_addr == REG_ZERO) begin
            rs1_data = '0;
        end else if (wb_commit && (bus.rs1_addr == bus.reg_rd_in)) begin
            rs1_data = wb_data;
        end
        if (bus.rs2_addr == REG_ZERO) begin
            rs2_data = '0;
        end else if (wb_commit && (bus.rs2_addr == bus.reg_rd_in)) begin
            rs2_data = wb_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            commit_count <= '0;
        end else if (wb_commit) begin
            commit_count <= commit_count + CNT_W'(1);
        end
    end

    assign bus.wb_data      = wb_data;
    assign bus.wb_commit    = wb_commit;
    assign bus.rs1_data     = rs1_data;
    assign bus.rs2_data     = rs2_data;
    assign bus.commit_count = commit_count;
endmodule

// File: tb/tb_wb_regfile.sv
// Randomized and directed bench for wb_regfile against an array-based register-file model.
module tb_wb_regfile;
    logic        clock;
    logic        reset;
    logic        m2r;
    logic        we;
    logic [31:0] rdv;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic [4:0]  a1;
    logic [4:0]  a2;

    int total = 0;
    int bad   = 0;

    logic [31:0] mregs [32];
    logic [31:0] mcnt;

    wb_regfile_if #(.XLEN(32), .CNT_W(32)) bus_a ();
    wb_regfile_if #(.XLEN(32), .CNT_W(4))  bus_b ();

    assign bus_a.mem_to_reg_in = m2r;
    assign bus_a.reg_write_in  = we;
    assign bus_a.read_data_in  = rdv;
    assign bus_a.alu_result_in = alu;
    assign bus_a.reg_rd_in     = rd;
    assign bus_a.rs1_addr      = a1;
    assign bus_a.rs2_addr      = a2;
    assign bus_b.mem_to_reg_in = m2r;
    assign bus_b.reg_write_in  = we;
    assign bus_b.read_data_in  = rdv;
    assign bus_b.alu_result_in = alu;
    assign bus_b.reg_rd_in     = rd;
    assign bus_b.rs1_addr      = a1;
    assign bus_b.rs2_addr      = a2;

    wb_regfile #(.XLEN(32), .NUM_REGS(32), .CNT_W(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_a)
    );

    wb_regfile #(.XLEN(32), .NUM_REGS(32), .CNT_W(4)) dut_w (
        .clock (clock),
        .reset (reset),
        .bus   (bus_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: registers as a plain array, commit counter as an integer.
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
            mcnt = 32'h0;
        end else if (we && rd != 5'd0) begin
            mregs[rd] = m2r ? rdv : alu;
            mcnt = mcnt + 1;
        end
    end

    function automatic logic [31:0] model_read(input logic [4:0] addr);
        logic [31:0] v;
        if (addr == 5'd0) v = 32'h0;
        else if (we && rd != 5'd0 && addr == rd) v = m2r ? rdv : alu;
        else v = mregs[addr];
        return v;
    endfunction

    always @(negedge clock) begin
        logic [31:0] exp_wb;
        logic [31:0] cnt_b;
        exp_wb = m2r ? rdv : alu;
        cnt_b  = {28'h0, mcnt[3:0]};
        check("wb_data", bus_a.wb_data, exp_wb);
        check("wb_commit", {31'h0, bus_a.wb_commit}, {31'h0, (we && rd != 5'd0)});
        check("rs1_data", bus_a.rs1_data, model_read(a1));
        check("rs2_data", bus_a.rs2_data, model_read(a2));
        check("commit_count", bus_a.commit_count, mcnt);
        check("commit_count_w4", {28'h0, bus_b.commit_count}, cnt_b);
    end

    task automatic drive(input logic m, input logic w, input logic [31:0] r,
                         input logic [31:0] a, input logic [4:0] d,
                         input logic [4:0] s1, input logic [4:0] s2);
        m2r = m; we = w; rdv = r; alu = a; rd = d; a1 = s1; a2 = s2;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        drive(0, 0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
        #2;
        check("reset_count", bus_a.commit_count, 32'h0);
        check("reset_rs1", bus_a.rs1_data, 32'h0);
        tick();
        tick();
        reset = 1'b1;

        // Mux select and write
        drive(0, 1, $urandom, 32'h0000_1234, 5'd3, 5'd3, 5'd4);
        tick();
        drive(1, 1, 32'hCAFE_F00D, $urandom, 5'd4, 5'd3, 5'd4);
        tick();
        drive(0, 0, $urandom, $urandom, 5'd9, 5'd3, 5'd4);
        #1;
        check("mux_x3", bus_a.rs1_data, 32'h0000_1234);
        check("mux_x4", bus_a.rs2_data, 32'hCAFE_F00D);
        check("mux_count", bus_a.commit_count, 32'd2);

        // x0 protection
        drive(0, 1, 32'h0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0);
        #1;
        check("x0_commit", {31'h0, bus_a.wb_commit}, 32'h0);
        check("x0_read_bypass", bus_a.rs1_data, 32'h0);
        tick();
        check("x0_read", bus_a.rs2_data, 32'h0);
        check("x0_count", bus_a.commit_count, 32'd2);

        // Bypass
        drive(0, 1, 32'h0, 32'h11, 5'd7, 5'd1, 5'd1);
        tick();
        drive(0, 1, 32'h0, 32'h22, 5'd7, 5'd7, 5'd7);
        #1;
        check("bypass_rs1", bus_a.rs1_data, 32'h22);
        check("bypass_rs2", bus_a.rs2_data, 32'h22);
        we = 1'b0;
        #1;
        check("nobypass_rs1", bus_a.rs1_data, 32'h11);
        check("nobypass_rs2", bus_a.rs2_data, 32'h11);
        tick();

        // Bubbles with random payload
        for (int i = 0; i < 10; i++) begin
            drive($urandom_range(0, 1), 0, $urandom, $urandom, 5'($urandom_range(0, 31)),
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            tick();
        end
        drive(0, 0, 32'h0, 32'h0, 5'd3, 5'd4, 5'd7);
        #1;
        check("bubble_x4", bus_a.rs1_data, 32'hCAFE_F00D);
        check("bubble_x7", bus_a.rs2_data, 32'h11);
        check("bubble_count", bus_a.commit_count, 32'd3);
        a1 = 5'd3;
        #1;
        check("bubble_x3", bus_a.rs1_data, 32'h0000_1234);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic [4:0] d;
            d = 5'($urandom_range(0, 31));
            drive($urandom_range(0, 1), ($urandom_range(0, 3) != 0), $urandom, $urandom, d,
                  ($urandom_range(0, 2) == 0) ? d : 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 2) == 0) ? d : 5'($urandom_range(0, 31)));
            tick();
        end

        // Asynchronous reset mid-cycle after writing x5
        drive(0, 1, 32'h0, 32'hDEAD_BEEF, 5'd5, 5'd5, 5'd5);
        tick();
        drive(0, 0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd5);
        #1;
        check("pre_reset_x5", bus_a.rs1_data, 32'hDEAD_BEEF);
        reset = 1'b0;
        #1;
        check("reset_x5", bus_a.rs1_data, 32'h0);
        check("reset_count_async", bus_a.commit_count, 32'h0);
        drive(0, 1, 32'h0, 32'h5555_AAAA, 5'd5, 5'd5, 5'd6);
        tick();
        check("reset_hold_count", bus_a.commit_count, 32'h0);
        drive(0, 0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd6);
        #1;
        check("reset_hold_x5", bus_a.rs1_data, 32'h0);
        reset = 1'b1;

        // Counter wrap with the 4-bit instance
        for (int i = 0; i < 17; i++) begin
            drive($urandom_range(0, 1), 1, $urandom, $urandom, 5'($urandom_range(1, 31)),
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            tick();
        end
        drive(0, 0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
        #1;
        check("wrap_count_w4", {28'h0, bus_b.commit_count}, 32'd1);
        check("wrap_count_w32", bus_a.commit_count, 32'd17);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
